// File: rtl/nclic_nest_ctrl.sv
// Nesting interrupt controller around an n_clic arbiter: per-source pend/en/prio state,
// running level with return stack, req/ack to the core. Optional macro: NCLIC_AUTOCLEAR_EN.
module nclic_nest_ctrl #(
    parameter int INT_AMOUNT = 8,
    parameter int PRIORITIES = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [INT_AMOUNT-1:0]               i_lines,
    input  logic                                i_global_ie,
    input  logic                                i_cfg_we,
    input  logic [$clog2(INT_AMOUNT)-1:0]       i_cfg_idx,
    input  logic [$clog2(PRIORITIES)+1:0]       i_cfg_data,
    output logic                                o_req,
    output logic [$clog2(INT_AMOUNT)-1:0]       o_idx,
    output logic [$clog2(PRIORITIES)-1:0]       o_prio,
    input  logic                                i_ack,
    input  logic                                i_ret,
    output logic [$clog2(PRIORITIES)-1:0]       o_level,
    output logic [$clog2(PRIORITIES)-1:0]       o_depth,
    output logic                                o_err
);

    localparam int IDX_W   = $clog2(INT_AMOUNT);
    localparam int PRIO_W  = $clog2(PRIORITIES);
    localparam int DEPTH_W = $clog2(PRIORITIES);
    localparam int STACK_N = PRIORITIES - 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_nxt;

    logic [INT_AMOUNT-1:0]             pend_p0, pend_nxt;
    logic [INT_AMOUNT-1:0]             en_p0, en_nxt;
    logic [INT_AMOUNT-1:0][PRIO_W-1:0] prio_p0, prio_nxt;
    logic [STACK_N-1:0][PRIO_W-1:0]    stack_q;

    logic              cand_irq;
    logic [IDX_W-1:0]  cand_idx;
    logic [PRIO_W-1:0] cand_prio;
    logic              latch_req;
    logic              ack_ok;
    logic              ret_ok;
    logic              err_set;

    n_clic #(
        .INT_AMOUNT (INT_AMOUNT),
        .IDX_W      (IDX_W),
        .PRIO_W     (PRIO_W)
    ) u_clic (
        .prio      (prio_p0),
        .pending   (pend_p0),
        .enable    (en_p0),
        .global_ie (i_global_ie),
        .irq       (cand_irq),
        .irq_idx   (cand_idx),
        .irq_prio  (cand_prio)
    );

    assign o_req   = (state == REQ);
    assign ack_ok  = (state == REQ) && i_ack;
    // A return coinciding with an ack is dropped; the ack owns the level update.
    assign ret_ok  = i_ret && !i_ack && (o_depth != '0);
    assign err_set = (i_ack && (state != REQ)) || (i_ret && (i_ack || (o_depth == '0)));

    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        case (state)
            IDLE: begin
                if (cand_irq && (cand_prio > o_level)) begin
                    state_nxt = REQ;
                    latch_req = 1'b1;
                end
            end
            REQ: begin
                if (i_ack || !i_global_ie) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Precedence: auto-clear, then explicit cfg write, then line set wins over both.
    always_comb begin
        pend_nxt = pend_p0;
        en_nxt   = en_p0;
        prio_nxt = prio_p0;
`ifdef NCLIC_AUTOCLEAR_EN
        if (ack_ok) begin
            pend_nxt[o_idx] = 1'b0;
        end
`endif
        if (i_cfg_we) begin
            pend_nxt[i_cfg_idx] = i_cfg_data[PRIO_W+1];
            en_nxt[i_cfg_idx]   = i_cfg_data[PRIO_W];
            prio_nxt[i_cfg_idx] = i_cfg_data[PRIO_W-1:0];
        end
        pend_nxt = pend_nxt | i_lines;
    end

    // Stage p0: registered source arrays feeding the arbiter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_p0 <= '0;
            en_p0   <= '0;
            prio_p0 <= '0;
        end else begin
            pend_p0 <= pend_nxt;
            en_p0   <= en_nxt;
            prio_p0 <= prio_nxt;
        end
    end

    // Stage p1: request outputs, running level, stack occupancy, error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            o_idx   <= '0;
            o_prio  <= '0;
            o_level <= '0;
            o_depth <= '0;
            o_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_req) begin
                o_idx  <= cand_idx;
                o_prio <= cand_prio;
            end
            if (ack_ok) begin
                o_level <= o_prio;
                o_depth <= o_depth + 1'b1;
            end else if (ret_ok) begin
                o_level <= stack_q[o_depth - 1'b1];
                o_depth <= o_depth - 1'b1;
            end
            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

    // Stack entries are only meaningful below o_depth, so they carry no reset.
    always_ff @(posedge clk) begin
        if (ack_ok) begin
            stack_q[o_depth] <= o_level;
        end
    end

    logic unused_depth_w;
    assign unused_depth_w = (DEPTH_W == PRIO_W);

endmodule

// Priority arbiter: highest non-zero priority among pending and enabled sources,
// ties resolved towards the lowest index, gated by the global enable.
module n_clic #(
    parameter int INT_AMOUNT = 8,
    parameter int IDX_W      = 3,
    parameter int PRIO_W     = 2
) (
    input  logic [INT_AMOUNT*PRIO_W-1:0] prio,
    input  logic [INT_AMOUNT-1:0]        pending,
    input  logic [INT_AMOUNT-1:0]        enable,
    input  logic                         global_ie,
    output logic                         irq,
    output logic [IDX_W-1:0]             irq_idx,
    output logic [PRIO_W-1:0]            irq_prio
);

    always_comb begin
        irq_idx  = '0;
        irq_prio = '0;
        // Strict compare keeps the earliest index on ties and never selects priority 0.
        for (int i = 0; i < INT_AMOUNT; i++) begin
            if (pending[i] && enable[i] && (prio[i*PRIO_W +: PRIO_W] > irq_prio)) begin
                irq_prio = prio[i*PRIO_W +: PRIO_W];
                irq_idx  = IDX_W'(i);
            end
        end
        irq = global_ie && (irq_prio != '0);
    end

endmodule

// File: doc/nclic_nest_ctrl.md
# nclic_nest_ctrl

Nesting controller wrapped around the `n_clic` arbitration tree. It owns the per-interrupt pending/enable/priority state and the current running priority level. It presents one interrupt at a time to the core over a req/ack handshake and tracks nested preemption with a level stack popped on return. It sits between the peripheral interrupt lines, the core's CSR write port and the core's trap logic.

## Interface
- `INT_AMOUNT`, 8: number of interrupt sources; `IDX_W = $clog2(INT_AMOUNT)`.
- `PRIORITIES`, 4: number of priority levels; `PRIO_W = $clog2(PRIORITIES)`; stack depth is `PRIORITIES-1`.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_lines` in INT_AMOUNT: level interrupt lines, bit i high sets pending[i].
- `i_global_ie` in 1: global interrupt enable from the core.
- `i_cfg_we` in 1: configuration write strobe.
- `i_cfg_idx` in IDX_W: source being written.
- `i_cfg_data` in PRIO_W+2: {pend, en, prio} written to source `i_cfg_idx`.
- `o_req` in→out 1: interrupt request to the core, registered.
- `o_idx` out IDX_W: index of requested interrupt, registered.
- `o_prio` out PRIO_W: priority of requested interrupt, registered.
- `i_ack` in 1: core takes the request this cycle.
- `i_ret` in 1: core returns from the current handler (mret).
- `o_level` out PRIO_W: current running priority level.
- `o_depth` out $clog2(PRIORITIES): stack occupancy.
- `o_err` out 1: sticky protocol-error flag, cleared only by reset.

## Operation
- Arbitration: internal `n_clic` instance fed with registered prio/pending/enable arrays and `i_global_ie`; highest priority wins, ties resolve to lowest index. Priority 0 never fires.
- Candidate is eligible when `n_clic` asserts its interrupt and candidate prio > `o_level` (strict).
- FSM states:
  - IDLE: `o_req`=0. Eligible candidate -> latch idx/prio into `o_idx`/`o_prio`, go REQ.
  - REQ: `o_req`=1; `o_idx`/`o_prio` held stable. `i_ack` -> push `o_level`, set `o_level`=`o_prio`, go IDLE. `i_global_ie`=0 without ack -> withdraw, go IDLE.
- Return: `i_ret` with `o_depth`>0 -> pop into `o_level`. `i_ret` with `o_depth`=0 -> ignored, `o_err` set.
- `i_ack` while `o_req`=0 -> ignored, `o_err` set.
- Simultaneous `i_ack` and `i_ret` -> ack processed, ret ignored, `o_err` set.
- Pending set by `i_lines` or a cfg write with pend=1; cleared by a cfg write with pend=0. Same-cycle line set and cfg clear on one source -> set wins.
- Stack cannot overflow because pushed levels are strictly increasing below PRIORITIES-1.
- A cfg write to the latched source while in REQ does not alter `o_idx`/`o_prio`.

## Timing
- Reset values: `o_req`=0, `o_idx`=0, `o_prio`=0, `o_level`=0, `o_depth`=0, `o_err`=0. All pending, enable and prio arrays are 0.
- Line or cfg change -> `o_req` high 2 cycles later (1 cycle array register, 1 cycle output register).
- Ack in cycle N -> `o_req`=0, `o_level`, `o_depth` and auto-clear updated at N+1. Earliest next request is N+2.
- Ret in cycle N -> `o_level`/`o_depth` updated at N+1. A pending candidate above the popped level raises `o_req` at N+2.
- Reset asserted mid-handshake -> all outputs return to reset values immediately (asynchronous).

## Configuration
- `NCLIC_AUTOCLEAR_EN` defined: on ack, pending[`o_idx`] clears at N+1 unless its line is high that same cycle (line set wins).
- Not defined: pending is cleared only by a cfg write with pend=0. Software must clear it in the handler; otherwise the source re-fires after return.

## Test plan
- Basic take: prio[2]=3, en[2]=1, line2 pulse, global_ie=1 -> `o_req`=1, `o_idx`=2, `o_prio`=3. Ack -> `o_level`=3, `o_depth`=1; with AUTOCLEAR, pending[2]=0.
- Tie and threshold: prio[1]=prio[5]=2, both pending/enabled -> `o_idx`=1. After ack, `o_level`=2 and source 5 is not requested.
- Nesting: take src4 (prio 1). Raise src2 (prio 3) -> request, ack -> `o_depth`=2, `o_level`=3. Ret -> `o_level`=1, `o_depth`=1. Ret -> `o_level`=0, `o_depth`=0.
- Withdrawal: in REQ, drop global_ie -> `o_req`=0 next cycle, `o_depth` unchanged, no `o_err`.
- Protocol errors: ret at depth 0 -> `o_err`=1, `o_level`=0. Ack with `o_req`=0 -> `o_err` stays 1, state unchanged. Simultaneous ack and ret -> ack taken, `o_err`=1.
- Reset: assert reset while in REQ at depth 2 -> all outputs and arrays read 0 immediately.
